// File: rtl/bcd_seq_conv.sv
// bcd_seq_conv: sequential double-dabble binary-to-BCD converter, one bit per clock with valid/ready handshakes.
// Define BCD_EARLY_DONE_EN to skip leading zero bits of the operand so latency tracks its bit length.
module bcd_seq_conv #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [19:0]      bcd,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] sh, sh_ld;
   logic [CW-1:0] cnt, cnt_ld;
   logic [19:0] adj;
   for (genvar g = 0; g < 5; g++) begin : g_adj
      assign adj[4*g +: 4] = bcd[4*g +: 4] >= 4'd5 ? bcd[4*g +: 4] + 4'd3 : bcd[4*g +: 4];
   end
`ifdef BCD_EARLY_DONE_EN
   // Left-align the operand so the first shift already moves its highest set bit.
   always_comb begin
      cnt_ld = CW'(1);
      for (int i = 0; i < WIDTH; i++)
         if (bin[i]) cnt_ld = CW'(i + 1);
      sh_ld = bin << (CW'(WIDTH) - cnt_ld);
   end
`else
   assign cnt_ld = CW'(WIDTH);
   assign sh_ld  = bin;
`endif
   always_comb begin
      state_nx = clr ? IDLE :
                 state == IDLE  ? (in_valid ? SHIFT : IDLE) :
                 state == SHIFT ? (cnt == CW'(1) ? DONE : SHIFT) :
                 (out_ready ? IDLE : DONE);
   end
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign busy      = state == SHIFT;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         bcd   <= '0;
         sh    <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (clr) begin
            bcd <= '0;
         end else if (state == IDLE && in_valid) begin
            sh  <= sh_ld;
            bcd <= '0;
            cnt <= cnt_ld;
         end else if (state == SHIFT) begin
            {bcd, sh} <= {adj, sh} << 1;
            cnt       <= cnt - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_bcd_seq_conv.sv
// tb_bcd_seq_conv: randomized self-checking bench for bcd_seq_conv at WIDTH=8 and WIDTH=16.
module tb_bcd_seq_conv;
   logic clk = 0, rst_n = 0;
   logic clr8 = 0, iv8 = 0, or8 = 0, ir8, ov8, busy8;
   logic clr16 = 0, iv16 = 0, or16 = 0, ir16, ov16, busy16;
   logic [7:0] b8 = 0;
   logic [15:0] b16 = 0;
   logic [19:0] bcd8, bcd16;
   int vecs = 0, errs = 0;

   always #5 clk = ~clk;

   bcd_seq_conv #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .clr(clr8), .in_valid(iv8), .in_ready(ir8),
      .bin(b8), .out_valid(ov8), .out_ready(or8), .bcd(bcd8), .busy(busy8));
   bcd_seq_conv #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .clr(clr16), .in_valid(iv16), .in_ready(ir16),
      .bin(b16), .out_valid(ov16), .out_ready(or16), .bcd(bcd16), .busy(busy16));

   // Reference: decimal digits by repeated division.
   function automatic logic [19:0] to_bcd(input int v);
      logic [19:0] r;
      r = '0;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic int exp_lat(input int v, input int w);
`ifdef BCD_EARLY_DONE_EN
      int n;
      n = 1;
      while ((1 << n) <= v) n++;
      return n;
`else
      return w;
`endif
   endfunction

   task automatic test_reset();
      #1;
      vecs++;
      if ({ir8, ov8, busy8, bcd8} !== {3'b100, 20'h0} || {ir16, ov16, busy16, bcd16} !== {3'b100, 20'h0}) begin
         errs++;
         $display("FAIL reset: got8=%b%b%b %h got16=%b%b%b %h want 100 00000", ir8, ov8, busy8, bcd8, ir16, ov16, busy16, bcd16);
      end
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_conv(input bit wide, input int v);
      int w, lat;
      w = wide ? 16 : 8;
      @(negedge clk);
      if (wide) begin iv16 = 1; b16 = 16'(v); end
      else begin iv8 = 1; b8 = 8'(v); end
      @(posedge clk);
      #1;
      iv8 = 0;
      iv16 = 0;
      vecs++;
      if ((wide ? busy16 : busy8) !== 1'b1) begin
         errs++;
         $display("FAIL busy_after_accept w=%0d v=%0d: got %b want 1", w, v, wide ? busy16 : busy8);
      end
      lat = 0;
      while ((wide ? ov16 : ov8) !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      vecs++;
      if (lat != exp_lat(v, w)) begin
         errs++;
         $display("FAIL latency w=%0d v=%0d: got %0d want %0d", w, v, lat, exp_lat(v, w));
      end
      vecs++;
      if ((wide ? bcd16 : bcd8) !== to_bcd(v)) begin
         errs++;
         $display("FAIL result w=%0d v=%0d: got %h want %h", w, v, wide ? bcd16 : bcd8, to_bcd(v));
      end
      if (wide) or16 = 1; else or8 = 1;
      @(posedge clk);
      #1;
      or8 = 0;
      or16 = 0;
      vecs++;
      if ((wide ? {ir16, ov16} : {ir8, ov8}) !== 2'b10 || (wide ? bcd16 : bcd8) !== to_bcd(v)) begin
         errs++;
         $display("FAIL handoff w=%0d v=%0d: got ir/ov=%b bcd=%h want 10 %h", w, v,
                  wide ? {ir16, ov16} : {ir8, ov8}, wide ? bcd16 : bcd8, to_bcd(v));
      end
   endtask

   task automatic test_sweep();
      int q[$];
      int v = 0, cyc = 0, last = -1, prev = 0;
      or8 = 1;
      iv8 = 1;
      while ((v < 256 || q.size() > 0) && cyc < 8000) begin
         @(negedge clk);
         cyc++;
         if (ov8) begin
            vecs++;
            if (q.size() == 0 || bcd8 !== to_bcd(q[0])) begin
               errs++;
               $display("FAIL sweep_result: got %h want %h", bcd8, q.size() ? to_bcd(q[0]) : 20'h0);
            end
            if (q.size()) void'(q.pop_front());
         end
         if (ir8 && v < 256) begin
            if (last >= 0) begin
               vecs++;
               if (cyc - last != exp_lat(prev, 8) + 2) begin
                  errs++;
                  $display("FAIL sweep_spacing v=%0d: got %0d want %0d", v, cyc - last, exp_lat(prev, 8) + 2);
               end
            end
            b8 = 8'(v);
            q.push_back(v);
            last = cyc;
            prev = v;
            v++;
         end else if (v >= 256) begin
            iv8 = 0;
         end
      end
      iv8 = 0;
      vecs++;
      if (q.size() != 0 || v != 256) begin
         errs++;
         $display("FAIL sweep_timeout: got pending=%0d sent=%0d want 0 256", q.size(), v);
      end
      @(negedge clk);
      or8 = 0;
   endtask

   task automatic test_backpressure();
      int v;
      v = $urandom_range(255);
      @(negedge clk);
      iv8 = 1;
      b8 = 8'(v);
      @(posedge clk);
      #1;
      iv8 = 0;
      for (int i = 0; i < 40 && !ov8; i++) @(posedge clk);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         iv8 = 1;
         b8 = 8'($urandom);
         @(posedge clk);
         #1;
         vecs++;
         if ({ir8, ov8} !== 2'b01 || bcd8 !== to_bcd(v)) begin
            errs++;
            $display("FAIL backpressure cyc=%0d: got ir/ov=%b bcd=%h want 01 %h", i, {ir8, ov8}, bcd8, to_bcd(v));
         end
      end
      @(negedge clk);
      iv8 = 0;
      or8 = 1;
      @(negedge clk);
      or8 = 0;
      test_conv(0, $urandom_range(255));
   endtask

   task automatic test_abort();
      @(negedge clk);
      iv8 = 1;
      b8 = 8'd200;
      @(negedge clk);
      iv8 = 0;
      repeat (2) @(negedge clk);
      clr8 = 1;
      @(posedge clk);
      #1;
      vecs++;
      if ({ir8, ov8, busy8} !== 3'b100 || bcd8 !== 20'h0) begin
         errs++;
         $display("FAIL clr_shift: got %b%b%b %h want 100 00000", ir8, ov8, busy8, bcd8);
      end
      @(negedge clk);
      iv8 = 1;
      @(posedge clk);
      #1;
      vecs++;
      if ({ir8, busy8} !== 2'b10) begin
         errs++;
         $display("FAIL clr_beats_valid: got ir/busy=%b want 10", {ir8, busy8});
      end
      @(negedge clk);
      iv8 = 0;
      clr8 = 0;
      @(negedge clk);
      iv8 = 1;
      b8 = 8'd99;
      @(negedge clk);
      iv8 = 0;
      repeat (3) @(negedge clk);
      rst_n = 0;
      #1;
      vecs++;
      if ({ir8, ov8, busy8} !== 3'b100 || bcd8 !== 20'h0) begin
         errs++;
         $display("FAIL async_reset: got %b%b%b %h want 100 00000", ir8, ov8, busy8, bcd8);
      end
      @(negedge clk);
      rst_n = 1;
      test_conv(0, 37);
   endtask

   initial begin
      test_reset();
      test_conv(0, 255);
      test_conv(0, 99);
      test_conv(0, 100);
      test_conv(0, 3);
      test_conv(0, 0);
      test_conv(0, 128);
      test_conv(1, 65535);
      test_conv(1, 10000);
      test_conv(1, 0);
      for (int i = 0; i < 20; i++) test_conv(1, $urandom_range(65535));
      for (int i = 0; i < 10; i++) test_conv(0, $urandom_range(255));
      test_sweep();
      test_backpressure();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/bcd_seq_conv.md
# bcd_seq_conv

Sequential binary-to-BCD converter with a valid/ready handshake on both sides. It uses one shift-add-3 (double-dabble) digit-adjust stage, iterated once per clock over the input bits. It replaces wide combinational BCD adder chains where area matters more than latency, and feeds display/readout paths that consume packed BCD digits.

## Interface
- WIDTH, 8: binary input width; legal range 4..16.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort: returns the block to IDLE next edge and clears bcd; has priority over all handshakes.
- in_valid  in  1  bin is valid.
- in_ready  out  1  block can accept; high only in IDLE.
- bin  in  WIDTH  unsigned binary operand.
- out_valid  out  1  bcd holds a finished result; high only in DONE.
- out_ready  in  1  consumer takes the result.
- bcd  out  20  packed BCD, 5 digits; bcd[3:0] = units, bcd[19:16] = ten-thousands; unused upper digits are 0.
- busy  out  1  high in SHIFT.

## Operation
- States: IDLE, SHIFT, DONE; 2-bit state register.
- IDLE:
  - in_ready=1.
  - On in_valid: capture bin into shift register sh, bcd<=0, cnt<=WIDTH, go to SHIFT.
- SHIFT, one step per cycle:
  - Each 4-bit digit of bcd that is >=5 gets +3 (all 5 digits in parallel).
  - Then {bcd,sh} shifts left by 1, MSB of sh entering bcd[0].
  - cnt decrements.
  - The step taken when cnt==1 is the last; go to DONE.
- DONE:
  - out_valid=1; bcd stable.
  - On out_ready go to IDLE; bcd keeps its value until the next accept.
- Adjust arithmetic: per digit 4-bit; digit values never exceed 9 after the shift, and the +3 never carries out of its nibble.
- bcd is an output register. No combinational path from bin to bcd, or from out_ready to in_ready.
- in_valid is ignored outside IDLE; bin is sampled only on the accepting edge.
- Maximum result is 65535 for WIDTH=16, so 5 digits always suffice and there is no overflow.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, bcd=0, sh=0, cnt=0. Outputs: out_valid=0, busy=0, in_ready=1.
- Latency:
  - Accept on edge E0 (in_valid & in_ready).
  - busy is high after E0 through edge E(WIDTH).
  - out_valid rises after edge E(WIDTH): WIDTH cycles from accept.
- Throughput: one conversion per WIDTH+2 cycles minimum. DONE with out_ready at edge Ed; in_ready is high after Ed; the next accept is at Ed+1.
- out_ready held low: DONE persists indefinitely with bcd stable.
- clr:
  - In any state: next edge gives IDLE, bcd=0, out_valid=0.
  - clr together with in_valid in IDLE: clr wins, nothing accepted.
- Reset mid-SHIFT: immediate return to reset values; the partial result is discarded.

## Configuration
- BCD_EARLY_DONE_EN:
  - Defined: at accept, sh is loaded left-aligned so its MSB is the highest set bit of bin. cnt is set to (index of highest set bit)+1. bin==0 loads cnt=1, giving one SHIFT cycle and result 0. Latency = cnt cycles.
  - Undefined: fixed latency of WIDTH cycles for every operand.
- Results are identical either way; only latency differs.

## Test plan
- WIDTH=8, bin=8'd255, out_ready=1 → out_valid rises 8 cycles after accept, bcd=20'h00255, back in IDLE 1 cycle later.
- WIDTH=8, sweep bin=0..255 back-to-back → every bcd matches the decimal value (e.g. 99→20'h00099, 100→20'h00100). Accepts are spaced exactly 10 cycles apart with the macro off.
- WIDTH=16, bin=16'd65535 → bcd=20'h65535 after 16 cycles; bin=16'd10000 → 20'h10000.
- Back-pressure: out_ready=0 for 20 cycles after done → out_valid and bcd stable, in_ready=0, new in_valid ignored. Release → result taken, next operand accepted.
- Abort and reset: clr pulsed 3 cycles into SHIFT → IDLE next edge, bcd=0. rst_n pulsed low mid-SHIFT → all outputs at reset values asynchronously, and the next conversion of bin=8'd37 gives 20'h00037.
- BCD_EARLY_DONE_EN defined, WIDTH=8: bin=3 → out_valid 2 cycles after accept, bcd=20'h00003; bin=0 → 1 cycle, bcd=0; bin=128 → 8 cycles, bcd=20'h00128.
